// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO.
// Holds the default word width and depth used by sync_fifo, fifo_mem,
// fifo_intf and the test bench, plus a helper for the occupancy width.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_intf.sv
// Bundle of the sync_fifo signals for connecting a producer/consumer pair.
// Ports:
//   clk   - FIFO clock
//   rst_n - asynchronous active-low reset
// Modports: dut (FIFO side), host (producer/consumer side).
interface fifo_intf
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic clk,
    input logic rst_n
);

    logic                               wr_en;
    logic [FIFO_WIDTH-1:0]              wr_data;
    logic                               rd_en;
    logic [FIFO_WIDTH-1:0]              rd_data;
    logic                               rd_valid;
    logic                               full;
    logic                               empty;
    logic                               almost_full;
    logic                               almost_empty;
    logic [cnt_width(FIFO_DEPTH)-1:0]   count;
    logic                               overflow;
    logic                               underflow;

    modport dut (
        input  clk, rst_n, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport host (
        input  clk, rst_n, rd_data, rd_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow,
        output wr_en, wr_data, rd_en
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one write port and one registered read port.
// The array itself is never reset; only the read-data register is, so the
// FIFO output reads as zero straight out of reset.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (read register only)
//   wr_en       - write wr_data to wr_addr at the rising edge
//   wr_addr     - write address
//   wr_data     - write word
//   rd_en       - load rd_data from rd_addr at the rising edge
//   rd_addr     - read address
//   rd_data     - registered read word, holds when rd_en is low
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_FIFO_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // When full with a simultaneous read and write, both addresses match;
    // the non-blocking update means the read returns the old (oldest) word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold
// flags and one-cycle overflow/underflow pulses.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   wr_en, wr_data - write request and word
//   rd_en          - read request
//   rd_data        - registered read word (holds between accepted reads)
//   rd_valid       - one-cycle pulse: rd_data was loaded at this edge
//   full, empty    - count == FIFO_DEPTH / count == 0
//   almost_full    - count >= AF_LEVEL
//   almost_empty   - count <= AE_LEVEL
//   count          - occupancy 0..FIFO_DEPTH
//   overflow       - one-cycle pulse on a rejected write
//   underflow      - one-cycle pulse on a rejected read
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [FIFO_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    output logic [FIFO_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = cnt_width(FIFO_DEPTH);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;
    logic [CW-1:0] count_nxt;

    // No fall-through: a read needs data already stored. A write into a full
    // FIFO is still fine when a read frees a slot at the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    // Depth is a power of two, so the natural roll-over of a PW-bit pointer
    // is the required wrap from FIFO_DEPTH-1 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Flags are derived from the next count so they register in the same
    // edge as count and always agree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == CW'(FIFO_DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (int'(count_nxt) >= AF_LEVEL);
            almost_empty <= (int'(count_nxt) <= AE_LEVEL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= rd_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && empty;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based occupancy/data model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int W  = DEF_FIFO_WIDTH;
    localparam int D  = DEF_FIFO_DEPTH;
    localparam int CW = cnt_width(D);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] exp_rd_data = '0;
    logic         exp_valid = 1'b0;
    logic         exp_ovf = 1'b0;
    logic         exp_udf = 1'b0;

    logic [W-1:0] pattern [8] = '{8'hFF, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h01, 8'h03, 8'h07};

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // One clock edge with the given request; updates the model from the
    // FIFO rules (no comparisons here). Returns 1 ns after the edge.
    task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
        bit rd_ok, wr_ok;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        rd_ok     = re && (q.size() > 0);
        wr_ok     = we && ((q.size() < D) || rd_ok);
        exp_ovf   = we && !wr_ok;
        exp_udf   = re && (q.size() == 0);
        exp_valid = rd_ok;
        if (rd_ok) exp_rd_data = q.pop_front();
        if (wr_ok) q.push_back(wd);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_data = '0;
        exp_valid   = 1'b0;
        exp_ovf     = 1'b0;
        exp_udf     = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (empty !== 1'b1 || count !== '0 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got empty=%b count=%0d full=%b ae=%b af=%b, expected 1 0 0 1 0", empty, count, full, almost_empty, almost_full);
        end
        n_cmp++; if (rd_data !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b ovf=%b udf=%b, expected 00 0 0 0", rd_data, rd_valid, overflow, underflow);
        end
        rst_n = 1'b1;
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA1 || count !== CW'(1)) begin
            n_fail++; $display("FAIL pre_reset_read: got rd_valid=%b rd_data=%h count=%0d, expected 1 a1 1", rd_valid, rd_data, count);
        end
        // Mid-cycle asynchronous reset, released before the next edge
        wr_en = 1'b0; rd_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1 || count !== '0 || full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
            n_fail++; $display("FAIL async_reset: got empty=%b count=%0d full=%b rd_valid=%b rd_data=%h, expected 1 0 0 0 00", empty, count, full, rd_valid, rd_data);
        end
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (empty !== 1'b1 || count !== '0 || full !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got empty=%b count=%0d full=%b rd_valid=%b, expected 1 0 0 0", empty, count, full, rd_valid);
        end
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pattern[i], 1'b0);
            if (i == 6) begin
                n_cmp++; if (count !== CW'(7) || almost_full !== 1'b1 || full !== 1'b0) begin
                    n_fail++; $display("FAIL fill_af7: got count=%0d af=%b full=%b, expected 7 1 0", count, almost_full, full);
                end
            end
        end
        n_cmp++; if (full !== 1'b1 || count !== CW'(8) || almost_full !== 1'b1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got full=%b count=%0d af=%b empty=%b, expected 1 8 1 0", full, count, almost_full, empty);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== pattern[i]) begin
                n_fail++; $display("FAIL drain_data[%0d]: got valid=%b data=%h, expected 1 %h", i, rd_valid, rd_data, pattern[i]);
            end
        end
        n_cmp++; if (empty !== 1'b1 || count !== '0 || almost_empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d ae=%b, expected 1 0 1", empty, count, almost_empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) step(1'b1, pattern[i], 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        n_cmp++; if (overflow !== 1'b1 || count !== CW'(8) || full !== 1'b1) begin
            n_fail++; $display("FAIL overflow_pulse: got ovf=%b count=%0d full=%b, expected 1 8 1", overflow, count, full);
        end
        step(1'b0, 8'h00, 1'b0);
        n_cmp++; if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_once: got ovf=%b, expected 0", overflow);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++; if (rd_data === 8'h5A || rd_data !== exp_rd_data) begin
                n_fail++; $display("FAIL overflow_drain[%0d]: got %h, expected %h (never 5a)", i, rd_data, exp_rd_data);
            end
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1);
        n_cmp++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h07 || count !== '0) begin
            n_fail++; $display("FAIL underflow_pulse: got udf=%b valid=%b data=%h count=%0d, expected 1 0 07 0", underflow, rd_valid, rd_data, count);
        end
        step(1'b0, 8'h00, 1'b0);
        n_cmp++; if (underflow !== 1'b0 || rd_data !== 8'h07) begin
            n_fail++; $display("FAIL underflow_once: got udf=%b data=%h, expected 0 07", underflow, rd_data);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) step(1'b1, pattern[i], 1'b0);
        step(1'b1, 8'h11, 1'b1);
        n_cmp++; if (rd_data !== 8'hFF || rd_valid !== 1'b1 || count !== CW'(8) || overflow !== 1'b0 || full !== 1'b1) begin
            n_fail++; $display("FAIL simul_full: got data=%h valid=%b count=%0d ovf=%b full=%b, expected ff 1 8 0 1", rd_data, rd_valid, count, overflow, full);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++; if (rd_data !== exp_rd_data) begin
                n_fail++; $display("FAIL simul_drain[%0d]: got %h, expected %h", i, rd_data, exp_rd_data);
            end
        end
        n_cmp++; if (rd_data !== 8'h11) begin
            n_fail++; $display("FAIL simul_last: got %h, expected 11", rd_data);
        end
        step(1'b1, 8'h22, 1'b1);
        n_cmp++; if (underflow !== 1'b1 || count !== CW'(1) || rd_valid !== 1'b0 || empty !== 1'b0 || rd_data !== 8'h11) begin
            n_fail++; $display("FAIL simul_empty: got udf=%b count=%0d valid=%b empty=%b data=%h, expected 1 1 0 0 11", underflow, count, rd_valid, empty, rd_data);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++; if (rd_data !== 8'h22 || rd_valid !== 1'b1 || empty !== 1'b1) begin
            n_fail++; $display("FAIL simul_readback: got data=%h valid=%b empty=%b, expected 22 1 1", rd_data, rd_valid, empty);
        end
    endtask

    task automatic test_wrap_mid_reset();
        logic [W-1:0] d;
        for (int i = 0; i < 20; i++) begin
            d = W'($urandom);
            step(1'b1, d, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== d || rd_data !== exp_rd_data || empty !== 1'b1) begin
                n_fail++; $display("FAIL wrap_pair[%0d]: got valid=%b data=%h empty=%b, expected 1 %h 1", i, rd_valid, rd_data, empty, d);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0);
        n_cmp++; if (count !== CW'(3)) begin
            n_fail++; $display("FAIL pre_mid_reset_count: got %0d, expected 3", count);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1 || count !== '0 || almost_empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got empty=%b count=%0d ae=%b full=%b, expected 1 0 1 0", empty, count, almost_empty, full);
        end
        #1 rst_n = 1'b1;
        model_reset();
        step(1'b0, 8'h00, 1'b1);
        n_cmp++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL post_reset_read: got udf=%b valid=%b data=%h, expected 1 0 00", underflow, rd_valid, rd_data);
        end
    endtask

    task automatic test_random();
        logic we, re;
        int   sz;
        for (int i = 0; i < 400; i++) begin
            // Bias phases so the run spends time near both full and empty.
            if ((i / 50) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            step(we, W'($urandom), re);
            sz = q.size();
            n_cmp++; if (count !== CW'(sz) || full !== (sz == D) || empty !== (sz == 0) ||
                         almost_full !== (sz >= D - 1) || almost_empty !== (sz <= 1)) begin
                n_fail++; $display("FAIL rand_occ[%0d]: got count=%0d f=%b e=%b af=%b ae=%b, expected count=%0d", i, count, full, empty, almost_full, almost_empty, sz);
            end
            n_cmp++; if (rd_valid !== exp_valid || rd_data !== exp_rd_data || overflow !== exp_ovf || underflow !== exp_udf) begin
                n_fail++; $display("FAIL rand_out[%0d]: got valid=%b data=%h ovf=%b udf=%b, expected %b %h %b %b", i, rd_valid, rd_data, overflow, underflow, exp_valid, exp_rd_data, exp_ovf, exp_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries; power of two, at least 4.
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_data, input, FIFO_WIDTH, write word.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port rd_data, output, FIFO_WIDTH, registered read word.
REQ-011 SHALL have port rd_valid, output, 1, one-cycle pulse; rd_data was updated at this edge.
REQ-012 SHALL have ports full and empty, output, 1 each, occupancy flags.
REQ-013 SHALL have ports almost_full and almost_empty, output, 1 each, threshold flags.
REQ-014 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, current occupancy 0..FIFO_DEPTH.
REQ-015 SHALL have ports overflow and underflow, output, 1 each, one-cycle error pulses.

Function
REQ-016 A write SHALL be accepted at an edge where wr_en=1 and (full=0 or an accepted read occurs at the same edge).
REQ-017 A read SHALL be accepted at an edge where rd_en=1 and empty=0; there is no fall-through, so a write to an empty FIFO at the same edge does not satisfy the read.
REQ-018 An accepted read SHALL load the oldest entry into rd_data at that edge and pulse rd_valid high for one cycle; rd_data SHALL hold its value otherwise.
REQ-019 Write and read pointers SHALL be $clog2(FIFO_DEPTH) bits and SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-020 count SHALL increment on write-only, decrement on read-only, and hold on both or neither.
REQ-021 full SHALL equal (count==FIFO_DEPTH), empty SHALL equal (count==0), almost_full SHALL equal (count>=AF_LEVEL), and almost_empty SHALL equal (count<=AE_LEVEL); all SHALL be registered together with count.
REQ-022 A rejected write (wr_en=1 and full=1 with no accepted read) SHALL pulse overflow for one cycle and leave contents, pointers and count unchanged.
REQ-023 A rejected read (rd_en=1 and empty=1) SHALL pulse underflow for one cycle and leave rd_data unchanged, with no rd_valid pulse.
REQ-024 Full plus simultaneous rd_en and wr_en SHALL perform both operations; count stays FIFO_DEPTH and overflow stays 0.
REQ-025 Empty plus simultaneous rd_en and wr_en SHALL accept the write only, set count to 1 and pulse underflow.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, clear both pointers, set count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0 and underflow=0.
REQ-027 Reset asserted during any operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-028 Release of rst_n SHALL be synchronised externally; the first accepted operation SHALL occur at the first rising edge with rst_n=1.

Structure
REQ-029 Package fifo_pkg SHALL hold the default FIFO_WIDTH and FIFO_DEPTH constants, shared with fifo_intf and the test bench.
REQ-030 Storage SHALL be a sub-module fifo_mem with one write port and one registered read port, and no reset on the array.
REQ-031 Pointer, count, flag and error logic SHALL reside in sync_fifo.

Verification
REQ-032 Reset check: assert rst_n=0 mid-clock, then release -> empty=1, count=0, full=0, rd_valid=0 before the next edge.
REQ-033 Fill and drain: write FF,AA,55,0F,F0,01,03,07 -> full=1, almost_full=1 at count=7; then 8 reads return FF,AA,55,0F,F0,01,03,07 in order -> empty=1, count=0.
REQ-034 Overflow: at full, write 0x5A alone -> overflow pulses once, count=8, and a subsequent drain never returns 0x5A.
REQ-035 Underflow: at empty, read -> underflow pulses once, rd_valid=0, rd_data keeps its last value (07 after the drain).
REQ-036 Simultaneous read and write: at full, write 0x11 with a read -> rd_data=FF, count=8; at empty, write 0x22 with a read -> underflow=1, count=1.
REQ-037 Wrap and mid-reset: perform 20 interleaved write/read pairs so the pointers wrap twice with data intact; then pull rst_n low at count=3 -> empty=1 immediately, and the next read gives underflow.
